// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared types and constants for the parametrised register file.
//   clr_state_t   : bulk-clear engine state (IDLE / CLEARING)
//   REG_ZERO_ADDR : address of the hardwired-zero register
// ---------------------------------------------------------------------------
package reg_file_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_t;

    localparam int REG_ZERO_ADDR = 0;

endpackage

// File: rtl/rf_clear_seq.sv
// ---------------------------------------------------------------------------
// rf_clear_seq
// Sequential bulk-clear engine. A CLR seen in IDLE starts a walk over
// addresses 1..DEPTH-1, zeroing one register per clock.
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   async active-high reset (aborts a clear in progress)
//   clr_i      in   bulk-clear request, sampled on clk_i
//   clr_we_o   out  zero the register at clr_addr_o on this edge
//   clr_addr_o out  register currently being cleared
//   busy_o     out  engine running; write ports and bypass are locked out
// ---------------------------------------------------------------------------
module rf_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              busy_o
);

    // Register 0 is never stored, so the walk starts at 1 and stops at the
    // all-ones address without wrapping.
    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= CNT_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEARING;
                    cnt_d   = CNT_FIRST;
                end
            end
            CLEARING: begin
                // CLR is ignored here: a running clear is never restarted.
                clr_we_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_FIRST;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_FIRST;
            end
        endcase
    end

    assign clr_addr_o = cnt_q;
    assign busy_o     = (state_q == CLEARING);

endmodule

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parametrised register file: two combinational read ports, two write ports
// (port 1 has priority on address collision), register 0 hardwired to zero,
// optional same-cycle write-to-read bypass and a sequential bulk clear.
// Ports:
//   Clk, Rst          clock (rising) / async active-high reset
//   WEN0, RW0, busW0  write port 0
//   WEN1, RW1, busW1  write port 1 (wins on same address)
//   RX, RY            read addresses
//   busX, busY        read data (combinational, zero while Rst high)
//   CLR               bulk-clear request
//   BUSY              high while the clear engine runs
// ---------------------------------------------------------------------------
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WEN0,
    input  logic [ADDR_W-1:0] RW0,
    input  logic [DATA_W-1:0] busW0,
    input  logic              WEN1,
    input  logic [ADDR_W-1:0] RW1,
    input  logic [DATA_W-1:0] busW1,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY,
    input  logic              CLR,
    output logic              BUSY
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(REG_ZERO_ADDR);

    // Only registers 1..DEPTH-1 exist; address 0 is decoded to a constant.
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy;

    rf_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .clr_i      (CLR),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );

    assign BUSY = busy;

    // Write priority per register: clear engine, then port 1, then port 0.
    // While the engine runs, port writes are simply dropped.
    always_comb begin
        for (int k = 1; k < DEPTH; k++) begin
            regs_d[k] = regs_q[k];
            if (busy) begin
                if (clr_we && clr_addr == ADDR_W'(k)) regs_d[k] = '0;
            end else if (WEN1 && RW1 == ADDR_W'(k)) begin
                regs_d[k] = busW1;
            end else if (WEN0 && RW0 == ADDR_W'(k)) begin
                regs_d[k] = busW0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int k = 1; k < DEPTH; k++) regs_q[k] <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) regs_q[k] <= regs_d[k];
        end
    end

    // Read mux with optional forwarding of this cycle's write data.
    function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (a == ADDR_W'(k)) r = regs_q[k];
        end
        if (BYPASS != 0 && !busy && a != ZERO) begin
            if (WEN1 && RW1 == a)      r = busW1;
            else if (WEN0 && RW0 == a) r = busW0;
        end
        return r;
    endfunction

    always_comb begin
        busX = rd_mux(RX);
        busY = rd_mux(RY);
        if (Rst) begin
            busX = '0;
            busY = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          WEN0, WEN1, CLR;
    logic [AW-1:0] RW0, RW1, RX, RY;
    logic [DW-1:0] busW0, busW1;
    logic [DW-1:0] bx1, by1, bx0, by0;
    logic          bsy1, bsy0;

    always #5 Clk = ~Clk;

    reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_byp (
        .Clk(Clk), .Rst(Rst),
        .WEN0(WEN0), .RW0(RW0), .busW0(busW0),
        .WEN1(WEN1), .RW1(RW1), .busW1(busW1),
        .RX(RX), .RY(RY), .busX(bx1), .busY(by1),
        .CLR(CLR), .BUSY(bsy1)
    );

    reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nob (
        .Clk(Clk), .Rst(Rst),
        .WEN0(WEN0), .RW0(RW0), .busW0(busW0),
        .WEN1(WEN1), .RW1(RW1), .busW1(busW1),
        .RX(RX), .RY(RY), .busX(bx0), .busY(by0),
        .CLR(CLR), .BUSY(bsy0)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: plain array of register contents plus the number of
    // clear cycles still to run and the next address the clear will zero.
    logic [DW-1:0] mem [DEPTH];
    int            clr_rem;
    int            cidx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (Rst || a == 0) return '0;
        if (byp && clr_rem == 0) begin
            if (WEN1 && RW1 == a) return busW1;
            if (WEN0 && RW0 == a) return busW0;
        end
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clr_rem = 0;
        cidx    = 1;
    endtask

    task automatic model_edge();
        if (Rst) return;
        if (clr_rem == 0) begin
            if (WEN0 && RW0 != 0) mem[RW0] = busW0;
            if (WEN1 && RW1 != 0) mem[RW1] = busW1;
            if (CLR) begin
                clr_rem = DEPTH - 1;
                cidx    = 1;
            end
        end else begin
            mem[cidx] = '0;
            cidx++;
            clr_rem--;
        end
    endtask

    task automatic drive(input logic w0, input int a0, input int d0,
                         input logic w1, input int a1, input int d1,
                         input int rx, input int ry, input logic clr);
        WEN0 = w0; RW0 = AW'(a0); busW0 = DW'(d0);
        WEN1 = w1; RW1 = AW'(a1); busW1 = DW'(d1);
        RX = AW'(rx); RY = AW'(ry); CLR = clr;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".x_byp"}, 32'(bx1), 32'(exp_rd(RX, 1'b1)));
        chk({tag, ".y_byp"}, 32'(by1), 32'(exp_rd(RY, 1'b1)));
        chk({tag, ".x_nob"}, 32'(bx0), 32'(exp_rd(RX, 1'b0)));
        chk({tag, ".y_nob"}, 32'(by0), 32'(exp_rd(RY, 1'b0)));
        chk({tag, ".busy1"}, 32'(bsy1), 32'(clr_rem != 0));
        chk({tag, ".busy0"}, 32'(bsy0), 32'(clr_rem != 0));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cyc(input string tag);
        #1 check_outs(tag);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset(input string tag);
        Rst = 1'b1;
        model_reset();
        #1;
        chk({tag, ".busy1_now"}, 32'(bsy1), 32'd0);
        chk({tag, ".busy0_now"}, 32'(bsy0), 32'd0);
        for (int a = 0; a < 4; a++) begin
            RX = AW'(a); RY = AW'(a + 4);
            #1;
            chk({tag, ".rx0"}, 32'(bx1 | bx0), 32'd0);
            chk({tag, ".ry0"}, 32'(by1 | by0), 32'd0);
        end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic fill();
        for (int i = 1; i < DEPTH; i++) begin
            drive(1, i, 8'h10 + i, 0, 0, 0, i, i - 1, 0);
            cyc("fill");
        end
    endtask

    // Runs a clear from IDLE and returns how many cycles BUSY stayed high.
    task automatic run_clear(input string tag, output int n);
        n = 0;
        drive(0, 0, 0, 0, 0, 0, 1, 7, 1);
        cyc({tag, ".start"});
        while (bsy1 && n < 20) begin
            n++;
            // A write during the clear must be lost.
            drive(n == 2, 7, 8'hEE, n == 3, 1, 8'h77, n, 7, n == 4);
            cyc({tag, ".run"});
        end
    endtask

    int nb;

    initial begin
        Rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge Clk);
        do_reset("rst_init");

        // Basic write then read, and write to register 0 dropped.
        drive(1, 3, 8'hA5, 0, 0, 0, 3, 0, 0); cyc("t2_wr");
        drive(0, 0, 0, 0, 0, 0, 3, 0, 0);
        #1 chk("t2_a5", 32'(bx0), 32'hA5);
        cyc("t2_rd");
        drive(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0); cyc("t2_wr0");
        drive(0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1 chk("t2_r0", 32'(bx1), 32'd0);
        cyc("t2_rd0");

        // Same-address collision and dual commit.
        drive(1, 5, 8'h11, 1, 5, 8'h22, 5, 5, 0); cyc("t3_coll");
        drive(0, 0, 0, 0, 0, 0, 5, 0, 0);
        #1 chk("t3_22", 32'(bx0), 32'h22);
        cyc("t3_rd");
        drive(1, 2, 8'h33, 1, 4, 8'h44, 2, 4, 0); cyc("t3_dual");
        drive(0, 0, 0, 0, 0, 0, 2, 4, 0);
        #1 chk("t3_both", 32'({bx0, by0}), 32'h3344);
        cyc("t3_rd2");

        // Bypass vs no bypass.
        drive(0, 0, 0, 1, 6, 8'h3C, 6, 6, 0);
        #1 chk("t4_byp", 32'(bx1), 32'h3C);
        chk("t4_nob", 32'(bx0), 32'h00);
        cyc("t4");
        drive(0, 0, 0, 0, 0, 0, 6, 0, 0); cyc("t4_after");

        // Full clear with lost writes.
        fill();
        run_clear("t5", nb);
        chk("t5_busy_len", 32'(nb), 32'd7);
        drive(0, 0, 0, 0, 0, 0, 7, 1, 0);
        #1 chk("t5_r7", 32'(bx1), 32'd0);
        cyc("t5_post");

        // Reset three cycles into a clear, then a full clear again.
        fill();
        drive(0, 0, 0, 0, 0, 0, 1, 7, 1); cyc("t6_start");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, i + 1, 7, 0); cyc("t6_run");
        end
        do_reset("t6_rst");
        fill();
        run_clear("t6b", nb);
        chk("t6_busy_len", 32'(nb), 32'd7);

        // Random traffic.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd_rst");
            end else begin
                drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                      $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 24) == 0);
                cyc("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
